serial_word_deser: RTL
======================

Name: serial_word_deser

Overview:
- Upstream stage for the 9-bit word consumer.
- Assembles a serial bit stream, LSB first, into WIDTH-bit words.
- Presents each word on a parallel output with a valid/ready handshake: word drives the consumer's a[8:0], word_valid drives its b strobe.
- Keeps a wrapping count of delivered words for debug.

Parameters:
- WIDTH, 9, data bits per word; legal range 2..16.
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- sdata  input  1  serial data bit.
- svalid  input  1  sdata is valid this cycle.
- sready  output  1  block accepts sdata this cycle.
- word  output  WIDTH  assembled word; stable while word_valid=1 and word_ready=0.
- word_valid  output  1  word holds an undelivered word.
- word_ready  input  1  consumer accepts word this cycle.
- word_cnt  output  CNT_W  number of words delivered (word_valid & word_ready), wraps modulo 2^CNT_W.
- err  output  1  parity error pulse; exists in both builds, tied 0 without PARITY_EN.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - bit_idx=0, shift register=0.
  - word=0, word_valid=0, word_cnt=0, err=0.
  - FSM state=SHIFT.
- Bit accept: a bit transfers when svalid & sready on a clock edge.
- FSM states: SHIFT, LAST.
  - SHIFT: each accepted bit is written to shreg[bit_idx] and bit_idx increments. When bit_idx reaches FRAME_LEN-1, go to LAST. FRAME_LEN=WIDTH (WIDTH+1 with PARITY_EN).
  - LAST: waits for the final bit of the frame.
- sready:
  - 1 in SHIFT.
  - In LAST: sready = !word_valid | word_ready. The final bit stalls only while the output register is occupied and not draining.
- Final bit accepted in LAST:
  - word <= assembled data, word_valid <= 1 on the next edge. Latency is 1 cycle from final-bit accept to word_valid=1.
  - bit_idx <= 0, state <= SHIFT.
- Output handshake:
  - word_valid & word_ready clears word_valid, unless a new final bit is accepted in the same cycle; then word_valid stays 1 and word takes the new value. Back-to-back delivery, no bubble.
  - word_cnt increments on every word_valid & word_ready, wraps 2^CNT_W-1 -> 0.
- Throughput: with svalid=1 and word_ready=1 continuously, one word per FRAME_LEN cycles.
- Partial words: bits of word N+1 are accepted in SHIFT while word N waits in the output register.
- Gaps: svalid=0 mid-frame holds bit_idx and shreg indefinitely. No timeout.
- Reset mid-frame discards partial bits and any pending word. word_cnt returns to 0.
- Output stability: word and word_valid never change while word_valid=1 & word_ready=0, except by reset.

Optional Feature:
- Macro: SERIAL_WORD_DESER_PARITY_EN.
- Defined:
  - FRAME_LEN=WIDTH+1; the last serial bit is even parity over the WIDTH data bits.
  - Final bit accept with mismatch: word dropped; word_valid and word unchanged; word_cnt unchanged; err=1 for exactly one cycle (the cycle after accept). bit_idx still returns to 0.
  - Final bit accept with match: behaves as the base build.
- Undefined: FRAME_LEN=WIDTH, err constant 0, no parity logic synthesised.

Decomposition:
- Package serial_word_deser_pkg:
  - state enum typedef (SHIFT, LAST).
  - function frame_len(WIDTH, parity_en).
  - function even_parity(data).
- Sub-module: none required. A natural optional one is serial_word_out_reg: the one-deep valid/ready output register with simultaneous load/drain, reusable by other stages.

Test Plan:
- Reset then stream bits 1,0,1,1,0,0,1,0,1 (LSB first), word_ready=1 -> word=9'h14D, word_valid=1 one cycle after the 9th bit, word_cnt=1.
- Hold word_ready=0, send 9 + 8 bits -> first word stays stable; sready=0 when the 9th bit of word 2 is offered; after word_ready=1, word 2 loads same cycle word 1 drains; word_cnt=2 after both taken.
- svalid toggles 1/0 every cycle for one frame of 9'h1FF -> word=9'h1FF after 17 cycles; no bit lost or duplicated.
- Assert rst after 5 bits of 9'h0AA, release, send 9'h155 -> output 9'h155 only, word_cnt=1.
- Deliver 256 words with CNT_W=8 -> word_cnt wraps to 0 on the 256th handshake.
- PARITY_EN: send 9'h003 with parity 1 (wrong) -> err pulse of 1 cycle, no word_valid, word_cnt unchanged. Same data with parity 0 -> word=9'h003 delivered, err=0.

Source files
------------

// File: rtl/serial_word_deser_pkg.sv
// Shared types and helpers for the serial word deserializer.
package serial_word_deser_pkg;

    localparam int unsigned MAX_WIDTH = 16;

    typedef enum logic {
        SHIFT = 1'b0,
        LAST  = 1'b1
    } state_t;

    // Serial bits per frame: data bits plus an optional trailing parity bit.
    function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_word_deser_if.sv
// Serial input and parallel word output bundle of the word deserializer.
interface serial_word_deser_if #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned CNT_W = 8
);
    logic             sdata;
    logic             svalid;
    logic             sready;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic [CNT_W-1:0] word_cnt;
    logic             err;

    modport master (
        output sdata, svalid, word_ready,
        input  sready, word, word_valid, word_cnt, err
    );

    modport slave (
        input  sdata, svalid, word_ready,
        output sready, word, word_valid, word_cnt, err
    );
endinterface

// File: rtl/serial_word_out_reg.sv
// One-deep valid/ready output register; a load in the same cycle as a drain keeps valid high.
module serial_word_out_reg #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_fire_c
);
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    assign o_fire_c = r_valid & i_ready;
    assign o_data   = r_data;
    assign o_valid  = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (o_fire_c) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/serial_word_deser.sv
// Assembles an LSB-first serial stream into WIDTH-bit words with a valid/ready output and delivered-word count.
// Build option: SERIAL_WORD_DESER_PARITY_EN appends an even parity bit per frame; bad frames are dropped and pulse err.
module serial_word_deser
    import serial_word_deser_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_word_deser_if.slave bus
);
`ifdef SERIAL_WORD_DESER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int unsigned FRAME_LEN = frame_len(WIDTH, PARITY_EN);
    localparam int unsigned SH_W      = FRAME_LEN - 1;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(FRAME_LEN - 2);

    state_t           r_state;
    logic [IDX_W-1:0] r_bit_idx;
    logic [SH_W-1:0]  r_shreg;
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_sready;
    logic             w_accept;
    logic             w_last_accept;
    logic             w_load;
    logic             w_fire;
    logic             w_word_valid;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_word;

    // The final bit may only enter when the output register is free or draining this cycle.
    assign w_sready      = (r_state == SHIFT) | ~w_word_valid | bus.word_ready;
    assign w_accept      = bus.svalid & w_sready;
    assign w_last_accept = w_accept & (r_state == LAST);

`ifdef SERIAL_WORD_DESER_PARITY_EN
    logic w_par_ok;
    logic r_err;

    // Shift register holds all data bits; the final serial bit is the parity bit.
    assign w_data   = r_shreg;
    assign w_par_ok = (even_parity(MAX_WIDTH'(r_shreg)) == bus.sdata);
    assign w_load   = w_last_accept & w_par_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_last_accept & ~w_par_ok;
        end
    end

    assign bus.err = r_err;
`else
    // The final serial bit is the data MSB and goes straight to the output register.
    assign w_data  = {bus.sdata, r_shreg};
    assign w_load  = w_last_accept;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SHIFT;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else if (w_accept) begin
            case (r_state)
                SHIFT: begin
                    for (int unsigned i = 0; i < SH_W; i++) begin
                        if (r_bit_idx == IDX_W'(i)) begin
                            r_shreg[i] <= bus.sdata;
                        end
                    end
                    r_bit_idx <= r_bit_idx + IDX_W'(1);
                    if (r_bit_idx == PRE_LAST_IDX) begin
                        r_state <= LAST;
                    end
                end
                LAST: begin
                    r_bit_idx <= '0;
                    r_state   <= SHIFT;
                end
            endcase
        end
    end

    serial_word_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_data   (w_data),
        .i_ready  (bus.word_ready),
        .o_data   (w_word),
        .o_valid  (w_word_valid),
        .o_fire_c (w_fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (w_fire) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

    assign bus.sready     = w_sready;
    assign bus.word       = w_word;
    assign bus.word_valid = w_word_valid;
    assign bus.word_cnt   = r_word_cnt;
endmodule
